// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between a controller (master) and the register bank (slave).
interface spi_reg_bank_if;
   logic ncs;
   logic sclk;
   logic copi;
   logic cipo;
   logic cipo_oe;

   modport master (output ncs, output sclk, output copi, input cipo, input cipo_oe);
   modport slave  (input ncs, input sclk, input copi, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI peripheral register bank: NUM_REGS x DATA_W registers written and read back
// over one SPI port. Frame = R/W bit, ADDR_W address bits, DATA_W data bits, MSB first.
// All SPI pins are oversampled by clk through 2-FF synchronisers.
module spi_reg_bank #(
   parameter int unsigned       NUM_REGS = 5,
   parameter int unsigned       DATA_W   = 8,
   parameter int unsigned       ADDR_W   = 7,
   parameter bit                CPOL     = 1'b0,
   parameter bit                CPHA     = 1'b0,
   parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   spi_reg_bank_if.slave              spi,
   output logic [NUM_REGS*DATA_W-1:0] regs_out,
   output logic                       wr_pulse,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic                       frame_err
);

   localparam int unsigned FRAME_L     = 1 + ADDR_W + DATA_W;
   localparam int unsigned CNT_W       = $clog2(FRAME_L + 1);
   localparam bit          SAMPLE_RISE = (CPOL == CPHA);

   typedef enum logic [2:0] {
      S_WAIT_IDLE,
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_HOLD,
      S_ERR
   } state_e;

   state_e              state_q, state_d;
   logic [2:0]          ncs_sync_q, ncs_sync_d;
   logic [2:0]          sclk_sync_q, sclk_sync_d;
   logic [1:0]          copi_sync_q, copi_sync_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                rw_q, rw_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic                cipo_q, cipo_d;
   logic                cipo_oe_q, cipo_oe_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic                wr_pulse_q, wr_pulse_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic                frame_err_q, frame_err_d;

   logic                ncs_s, ncs_rise, ncs_fall;
   logic                sclk_rise, sclk_fall;
   logic                sample_edge, shift_edge;
   logic                copi_s;
   logic                addr_hit;

   // Synchroniser shift paths; the third ncs/sclk stage only feeds edge detection.
   always_comb begin
      ncs_sync_d  = {ncs_sync_q[1:0], spi.ncs};
      sclk_sync_d = {sclk_sync_q[1:0], spi.sclk};
      copi_sync_d = {copi_sync_q[0], spi.copi};
   end

   // Edge decode on the synchronised pins.
   always_comb begin
      ncs_s       = ncs_sync_q[1];
      ncs_rise    = ncs_sync_q[1] & ~ncs_sync_q[2];
      ncs_fall    = ~ncs_sync_q[1] & ncs_sync_q[2];
      sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
      sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
      sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
      shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
      copi_s      = copi_sync_q[1];
   end

   // Frame FSM, shifters, commit and read-data path.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      data_d      = data_q;
      tx_d        = tx_q;
      cipo_d      = cipo_q;
      regs_d      = regs_q;
      wr_pulse_d  = 1'b0;
      wr_addr_d   = wr_addr_q;
      frame_err_d = 1'b0;
      addr_hit    = 1'b0;

      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (addr_q == ADDR_W'(i)) addr_hit = 1'b1;
      end

      case (state_q)
         S_WAIT_IDLE: begin
            if (ncs_s) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (ncs_fall) begin
               state_d = S_CMD;
               cnt_d   = '0;
            end
         end
         default: begin
            // ncs rising takes priority over any sclk edge seen on the same clk
            if (ncs_rise) begin
               state_d = S_IDLE;
               if (state_q == S_HOLD) begin
                  if (rw_q && addr_hit) begin
                     for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (addr_q == ADDR_W'(i)) regs_d[i] = data_q;
                     end
                     wr_pulse_d = 1'b1;
                     wr_addr_d  = addr_q;
                  end
               end else begin
                  frame_err_d = 1'b1;
               end
            end else if (sample_edge) begin
               if (cnt_q != CNT_W'(FRAME_L)) cnt_d = cnt_q + CNT_W'(1);
               case (state_q)
                  S_CMD: begin
                     rw_d    = copi_s;
                     state_d = S_ADDR;
                  end
                  S_ADDR: begin
                     addr_d = ADDR_W'({addr_q, copi_s});
                     if (cnt_q == CNT_W'(ADDR_W)) begin
                        state_d = S_DATA;
                        tx_d    = '0;
                        for (int unsigned i = 0; i < NUM_REGS; i++) begin
                           if (addr_d == ADDR_W'(i)) tx_d = regs_q[i];
                        end
                     end
                  end
                  S_DATA: begin
                     data_d = DATA_W'({data_q, copi_s});
                     if (cnt_q == CNT_W'(FRAME_L - 1)) state_d = S_HOLD;
                  end
                  S_HOLD: begin
                     state_d = S_ERR;
                  end
                  default: ;
               endcase
            end else if (shift_edge && (state_q == S_DATA) && !rw_q) begin
               cipo_d = tx_q[DATA_W-1];
               tx_d   = DATA_W'({tx_q, 1'b0});
            end
         end
      endcase

      // CIPO is only driven during the data phase of a read
      if ((state_q != S_DATA) || rw_q) cipo_d = 1'b0;
      cipo_oe_d = (state_q != S_WAIT_IDLE) && !ncs_s;
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_WAIT_IDLE;
         ncs_sync_q  <= '0;
         sclk_sync_q <= '0;
         copi_sync_q <= '0;
         cnt_q       <= '0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         tx_q        <= '0;
         cipo_q      <= 1'b0;
         cipo_oe_q   <= 1'b0;
         for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
         wr_pulse_q  <= 1'b0;
         wr_addr_q   <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ncs_sync_q  <= ncs_sync_d;
         sclk_sync_q <= sclk_sync_d;
         copi_sync_q <= copi_sync_d;
         cnt_q       <= cnt_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         tx_q        <= tx_d;
         cipo_q      <= cipo_d;
         cipo_oe_q   <= cipo_oe_d;
         regs_q      <= regs_d;
         wr_pulse_q  <= wr_pulse_d;
         wr_addr_q   <= wr_addr_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Flatten the register array into the output image.
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
      assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
   end

   assign spi.cipo    = cipo_q;
   assign spi.cipo_oe = cipo_oe_q;
   assign wr_pulse    = wr_pulse_q;
   assign wr_addr     = wr_addr_q;
   assign frame_err   = frame_err_q;

endmodule
